// File: rtl/latch_bank_arbiter_pkg.sv
// Shared types and default sizes for the two-requester latch-bank write arbiter.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/latch_bank_arbiter_if.sv
// Requester/read bus of the latch-bank arbiter; master = clients, slave = arbiter.
// Optional parity signals exist only when LATCH_BANK_PARITY_EN is defined.
interface latch_bank_arbiter_if
  import latch_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH_DEF)
);

  logic              ReqA;
  logic [ADDR_W-1:0] AddrA;
  logic [DATA_W-1:0] DataA;
  logic              AckA;
  logic              ReqB;
  logic [ADDR_W-1:0] AddrB;
  logic [DATA_W-1:0] DataB;
  logic              AckB;
  logic [ADDR_W-1:0] RdAddr;
  logic [DATA_W-1:0] RdData;
  logic              Busy;
`ifdef LATCH_BANK_PARITY_EN
  logic              ParInj;
  logic              ParErr;
`endif

  modport master (
    output ReqA, AddrA, DataA, ReqB, AddrB, DataB, RdAddr,
`ifdef LATCH_BANK_PARITY_EN
    output ParInj,
    input  ParErr,
`endif
    input  AckA, AckB, RdData, Busy
  );

  modport slave (
    input  ReqA, AddrA, DataA, ReqB, AddrB, DataB, RdAddr,
`ifdef LATCH_BANK_PARITY_EN
    input  ParInj,
    output ParErr,
`endif
    output AckA, AckB, RdData, Busy
  );

endinterface

// File: rtl/latch_bank_arbiter_bank.sv
// DEPTH x DATA_W storage with async clear, per-word write enable and read mux.
// Under LATCH_BANK_PARITY_EN each word also keeps an even-parity bit.
module latch_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
`ifdef LATCH_BANK_PARITY_EN
  input  logic              i_par_inj,
  output logic              o_par_err,
`endif
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the bank is reset word by word because a reset must clear stored data;
  // out-of-range addresses match no word, so such writes are simply dropped.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_we && i_waddr == ADDR_W'(i)) r_mem[i] <= i_wdata;
    end
  end

  // NOTE: default assignment first so the mux cannot infer a latch.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_addr == ADDR_W'(i)) o_rd_data = r_mem[i];
  end

`ifdef LATCH_BANK_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             w_rd_par;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_par <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_we && i_waddr == ADDR_W'(i)) r_par[i] <= (^i_wdata) ^ i_par_inj;
    end
  end

  always_comb begin
    w_rd_par = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_addr == ADDR_W'(i)) w_rd_par = r_par[i];
  end

  assign o_par_err = ^{o_rd_data, w_rd_par};
`endif

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter/sequencer (IDLE -> WRITE -> ACK) for a shared latch bank.
// Optional parity storage and injection enabled by LATCH_BANK_PARITY_EN.
module latch_bank_arbiter
  import latch_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  latch_bank_arbiter_if.slave  bus
);

  state_t            r_state;
  gnt_t              r_gnt;
  gnt_t              r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_busy;
  gnt_t              w_win;
  logic              w_we;
`ifdef LATCH_BANK_PARITY_EN
  logic              r_par_inj;
`endif

  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_win = GNT_A;
    if (bus.ReqA && bus.ReqB) w_win = (r_last_gnt == GNT_A) ? GNT_B : GNT_A;
    else if (bus.ReqB)        w_win = GNT_B;
  end

  // NOTE: all state and outputs update with non-blocking assignments at the edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= GNT_A;
      r_last_gnt <= GNT_B;
      r_addr     <= '0;
      r_data     <= '0;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_busy     <= 1'b0;
`ifdef LATCH_BANK_PARITY_EN
      r_par_inj  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ReqA || bus.ReqB) begin
            r_gnt   <= w_win;
            r_addr  <= (w_win == GNT_A) ? bus.AddrA : bus.AddrB;
            r_data  <= (w_win == GNT_A) ? bus.DataA : bus.DataB;
`ifdef LATCH_BANK_PARITY_EN
            r_par_inj <= bus.ParInj;
`endif
            r_busy  <= 1'b1;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_ack_a <= (r_gnt == GNT_A);
          r_ack_b <= (r_gnt == GNT_B);
          r_state <= ACK;
        end
        ACK: begin
          r_ack_a    <= 1'b0;
          r_ack_b    <= 1'b0;
          r_last_gnt <= r_gnt;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_we     = (r_state == WRITE);
  assign bus.AckA = r_ack_a;
  assign bus.AckB = r_ack_b;
  assign bus.Busy = r_busy;

  latch_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .i_we      (w_we),
    .i_waddr   (r_addr),
    .i_wdata   (r_data),
`ifdef LATCH_BANK_PARITY_EN
    .i_par_inj (r_par_inj),
    .o_par_err (bus.ParErr),
`endif
    .i_rd_addr (bus.RdAddr),
    .o_rd_data (bus.RdData)
  );

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: reset, single write, round-robin ties,
// input hold during service, reset mid-write, and parity under LATCH_BANK_PARITY_EN.
module tb_latch_bank_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  latch_bank_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  latch_bank_arbiter #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string tag);
    bus.RdAddr = a;
    #1;
    check(tag, bus.RdData, e);
  endtask

  // Request(s) already raised just after an edge with the FSM idle; runs one grant.
  task automatic serve(input bit is_b, input bit chg, input logic [1:0] wa,
                       input logic [7:0] oldv, input logic [7:0] newv, input string tag);
    bus.RdAddr = wa;
    tick;
    check({tag, "_busy"},   bus.Busy, 1);
    check({tag, "_w_acka"}, bus.AckA, 0);
    check({tag, "_w_ackb"}, bus.AckB, 0);
    check({tag, "_w_old"},  bus.RdData, oldv);
    if (chg) begin
      bus.DataA = 8'hFF;
      bus.AddrA = 2'd0;
    end
    tick;
    check({tag, "_acka"}, bus.AckA, !is_b);
    check({tag, "_ackb"}, bus.AckB, is_b);
    check({tag, "_new"},  bus.RdData, newv);
    if (is_b) bus.ReqB = 1'b0;
    else      bus.ReqA = 1'b0;
    tick;
    check({tag, "_i_acka"}, bus.AckA, 0);
    check({tag, "_i_ackb"}, bus.AckB, 0);
    check({tag, "_i_busy"}, bus.Busy, 0);
  endtask

  initial begin
    bus.ReqA = 1'b0; bus.AddrA = '0; bus.DataA = '0;
    bus.ReqB = 1'b0; bus.AddrB = '0; bus.DataB = '0;
    bus.RdAddr = '0;
`ifdef LATCH_BANK_PARITY_EN
    bus.ParInj = 1'b0;
`endif

    // Reset
    #12;
    check("rst_busy", bus.Busy, 0);
    check("rst_acka", bus.AckA, 0);
    check("rst_ackb", bus.AckB, 0);
    rst_n = 1'b1;
    tick;
    check("rel_busy", bus.Busy, 0);
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00, "rst_rd");
`ifdef LATCH_BANK_PARITY_EN
    check("rst_parerr", bus.ParErr, 0);
`endif

    // First tie after reset: A wins, B follows 3 cycles after AckA
    bus.ReqA = 1'b1; bus.AddrA = 2'd0; bus.DataA = 8'h11;
    bus.ReqB = 1'b1; bus.AddrB = 2'd1; bus.DataB = 8'h22;
    serve(1'b0, 1'b0, 2'd0, 8'h00, 8'h11, "tie1_a");
    serve(1'b1, 1'b0, 2'd1, 8'h00, 8'h22, "tie1_b");

    // Single write from A
    bus.ReqA = 1'b1; bus.AddrA = 2'd2; bus.DataA = 8'hA5;
    serve(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5, "single");
    tick;
    check("single_once", bus.AckA, 0);
    check("single_nob",  bus.AckB, 0);

    // Tie with LastGnt=A: B wins first
    bus.ReqA = 1'b1; bus.AddrA = 2'd0; bus.DataA = 8'h55;
    bus.ReqB = 1'b1; bus.AddrB = 2'd3; bus.DataB = 8'h66;
    serve(1'b1, 1'b0, 2'd3, 8'h00, 8'h66, "tie2_b");
    serve(1'b0, 1'b0, 2'd0, 8'h11, 8'h55, "tie2_a");

    // Address/data changed during WRITE are ignored
    bus.ReqA = 1'b1; bus.AddrA = 2'd1; bus.DataA = 8'h3C;
    serve(1'b0, 1'b1, 2'd1, 8'h22, 8'h3C, "hold");
    rd(2'd0, 8'h55, "hold_other");
    rd(2'd2, 8'hA5, "hold_keep");

    // Reset during WRITE aborts the write and clears the bank
    tick;
    bus.ReqB = 1'b1; bus.AddrB = 2'd2; bus.DataB = 8'h99;
    tick;
    check("mid_busy_pre", bus.Busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_busy", bus.Busy, 0);
    check("mid_ackb", bus.AckB, 0);
    for (int i = 0; i < 4; i++) rd(2'(i), 8'h00, "mid_rd");
    tick;
    check("mid_ackb2", bus.AckB, 0);
    check("mid_busy2", bus.Busy, 0);
    bus.ReqB = 1'b0;
    rst_n = 1'b1;
    tick;
    tick;
    check("post_acka", bus.AckA, 0);
    check("post_ackb", bus.AckB, 0);
    check("post_busy", bus.Busy, 0);
    rd(2'd2, 8'h00, "post_rd");

`ifdef LATCH_BANK_PARITY_EN
    // Parity: clean write, then injected error
    bus.ReqA = 1'b1; bus.AddrA = 2'd1; bus.DataA = 8'h07; bus.ParInj = 1'b0;
    serve(1'b0, 1'b0, 2'd1, 8'h00, 8'h07, "par0");
    check("par0_err", bus.ParErr, 0);
    bus.ReqA = 1'b1; bus.ParInj = 1'b1;
    serve(1'b0, 1'b0, 2'd1, 8'h07, 8'h07, "par1");
    bus.ParInj = 1'b0;
    check("par1_err", bus.ParErr, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
